// File: rtl/truth_table_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | truth_table_engine : runtime-loadable N_IN-input truth table with         |
// |                      registered queries and a full-table sweep            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module truth_table_engine #(
    parameter int                   N_IN        = 3,
    parameter logic [(2**N_IN)-1:0] RESET_TABLE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [(2**N_IN)-1:0]   cfg_table,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN-1:0]        in_bits,
    input  logic                   sweep_start,
    output logic                   out,
    output logic                   out_valid,
    output logic [N_IN-1:0]        out_row,
    output logic                   sweep_done,
    output logic [N_IN:0]          ones_count
);
    localparam int              TT_W     = 2**N_IN;
    localparam logic [1:0]      S_IDLE   = 2'd0;
    localparam logic [1:0]      S_SWEEP  = 2'd1;
    localparam logic [1:0]      S_DONE   = 2'd2;
    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(TT_W - 1);

    logic [1:0]      state_q, state_d;
    logic [TT_W-1:0] table_q, table_d;
    logic [N_IN-1:0] cnt_q, cnt_d;
    logic [N_IN:0]   acc_q, acc_d;
    logic            pend_q, pend_d;
    logic            out_q, out_d;
    logic            valid_q, valid_d;
    logic [N_IN-1:0] row_q, row_d;
    logic            done_q, done_d;
    logic [N_IN:0]   ones_q, ones_d;

    logic            w_cfg_acc;
    logic            w_qry_acc;
    logic            w_sweep_go;
    logic [N_IN-1:0] w_next_row;

    assign w_cfg_acc  = cfg_valid & cfg_ready;
    assign w_qry_acc  = in_valid & in_ready;
    assign w_sweep_go = sweep_start & (state_q == S_IDLE);
    assign w_next_row = cnt_q + N_IN'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_sweep_go) state_d = S_SWEEP;
            S_SWEEP: if (!pend_q && (cnt_q == LAST_ROW)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == S_IDLE);
        in_ready  = (state_q == S_IDLE);
    end

    always_comb begin
        table_d = table_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        pend_d  = pend_q;
        out_d   = out_q;
        row_d   = row_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        ones_d  = ones_q;
        if (w_cfg_acc) begin
            table_d = cfg_table;
        end
        case (state_q)
            S_IDLE: begin
                if (w_qry_acc) begin
                    out_d   = table_q[in_bits];
                    row_d   = in_bits;
                    valid_d = 1'b1;
                end
                if (w_sweep_go) begin
                    cnt_d = '0;
                    // A same-cycle query owns this output slot; row 0 follows a cycle later.
                    if (w_qry_acc) begin
                        pend_d = 1'b1;
                        acc_d  = '0;
                    end else begin
                        pend_d  = 1'b0;
                        out_d   = table_d[0];
                        row_d   = '0;
                        valid_d = 1'b1;
                        acc_d   = {{N_IN{1'b0}}, table_d[0]};
                    end
                end
            end
            S_SWEEP: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    out_d   = table_q[0];
                    row_d   = '0;
                    valid_d = 1'b1;
                    acc_d   = {{N_IN{1'b0}}, table_q[0]};
                end else if (cnt_q == LAST_ROW) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    ones_d = acc_q;
                end else begin
                    cnt_d   = w_next_row;
                    out_d   = table_q[w_next_row];
                    row_d   = w_next_row;
                    valid_d = 1'b1;
                    acc_d   = acc_q + {{N_IN{1'b0}}, table_q[w_next_row]};
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            table_q <= RESET_TABLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            pend_q  <= 1'b0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            row_q   <= '0;
            done_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            table_q <= table_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            row_q   <= row_d;
            done_q  <= done_d;
            ones_q  <= ones_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = valid_q;
    assign out_row    = row_q;
    assign sweep_done = done_q;
    assign ones_count = ones_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_engine.sv
`default_nettype none
// Bench for truth_table_engine: vector table, directed corner sequences and
// randomized traffic checked against a cycle-timeline model.
module tb_truth_table_engine;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cfg_valid, in_valid, sweep_start;
    logic [7:0] cfg_table;
    logic [2:0] in_bits;
    logic       cfg_ready, in_ready, out, out_valid, sweep_done;
    logic [2:0] out_row;
    logic [3:0] ones_count;

    logic       c1_cfg_valid, c1_in_valid, c1_sweep;
    logic [1:0] c1_cfg_table;
    logic [0:0] c1_in_bits;
    logic       c1_cfg_ready, c1_in_ready, c1_out, c1_out_valid, c1_done;
    logic [0:0] c1_row;
    logic [1:0] c1_ones;

    truth_table_engine #(.N_IN(3), .RESET_TABLE(8'h00)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_table(cfg_table),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .sweep_start(sweep_start),
        .out(out), .out_valid(out_valid), .out_row(out_row),
        .sweep_done(sweep_done), .ones_count(ones_count)
    );

    truth_table_engine #(.N_IN(1), .RESET_TABLE(2'b00)) dut1 (
        .clk(clk), .rst(rst),
        .cfg_valid(c1_cfg_valid), .cfg_ready(c1_cfg_ready), .cfg_table(c1_cfg_table),
        .in_valid(c1_in_valid), .in_ready(c1_in_ready), .in_bits(c1_in_bits),
        .sweep_start(c1_sweep),
        .out(c1_out), .out_valid(c1_out_valid), .out_row(c1_row),
        .sweep_done(c1_done), .ones_count(c1_ones)
    );

    // Expected-output timeline, indexed by cycle number.
    bit         e_v [DEPTH];
    bit         e_o [DEPTH];
    logic [2:0] e_r [DEPTH];
    bit         e_d [DEPTH];
    bit         o_set [DEPTH];
    logic [3:0] o_val [DEPTH];

    int         cyc, ready_from, n_pass, n_total, cfg_took_at;
    logic [7:0] mtable;
    logic [3:0] cur_ones;
    bit         cfg_took;

    typedef struct {
        logic [7:0] tab;
        logic [2:0] q;
        logic       exp;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        int         c;
        int         s;
        logic [7:0] nt;
        c        = cyc;
        cfg_took = 1'b0;
        if (rst) begin
            for (int i = c + 1; i < DEPTH; i++) begin
                e_v[i] = 1'b0; e_d[i] = 1'b0; o_set[i] = 1'b0;
            end
            ready_from   = c + 1;
            mtable       = 8'h00;
            o_set[c + 1] = 1'b1;
            o_val[c + 1] = 4'd0;
        end else if (c >= ready_from) begin
            nt = mtable;
            if (cfg_valid) begin
                nt          = cfg_table;
                cfg_took    = 1'b1;
                cfg_took_at = c;
            end
            if (in_valid) begin
                e_v[c + 1] = 1'b1;
                e_o[c + 1] = mtable[in_bits];
                e_r[c + 1] = in_bits;
            end
            if (sweep_start) begin
                s = c + 1 + (in_valid ? 1 : 0);
                for (int r = 0; r < 8; r++) begin
                    e_v[s + r] = 1'b1;
                    e_o[s + r] = nt[r];
                    e_r[s + r] = 3'(r);
                end
                e_d[s + 8]   = 1'b1;
                o_set[s + 8] = 1'b1;
                o_val[s + 8] = 4'($countones(nt));
                ready_from   = s + 9;
            end
            mtable = nt;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (o_set[cyc]) cur_ones = o_val[cyc];
        chk("out_valid", out_valid, e_v[cyc]);
        if (e_v[cyc]) begin
            chk("out", out, e_o[cyc]);
            chk("out_row", out_row, e_r[cyc]);
        end
        chk("sweep_done", sweep_done, e_d[cyc]);
        chk("ones_count", ones_count, cur_ones);
        chk("cfg_ready", cfg_ready, cyc >= ready_from);
        chk("in_ready", in_ready, cyc >= ready_from);
    endtask

    // Steps n cycles (sweep_start already driven for the first), counting rows.
    task automatic observe(input int n, input bit repulse, input logic [7:0] pat,
                           output int nval, output int done_cyc, output int ones_at);
        nval = 0; done_cyc = -1; ones_at = -1;
        for (int i = 0; i < n; i++) begin
            step();
            sweep_start = (repulse && i == 2);
            if (out_valid) begin
                chk("sweep out", out, pat[out_row]);
                nval++;
            end
            if (sweep_done) begin
                done_cyc = cyc;
                ones_at  = int'(ones_count);
            end
        end
        sweep_start = 1'b0;
    endtask

    task automatic load(input logic [7:0] t);
        cfg_valid = 1'b1; cfg_table = t;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, nval, dcy, ones_at, guard;
        logic [7:0] pat;
        vecs[0] = '{8'hA5, 3'd0, 1'b1};
        vecs[1] = '{8'hA5, 3'd1, 1'b0};
        vecs[2] = '{8'hA5, 3'd5, 1'b1};
        vecs[3] = '{8'hA5, 3'd6, 1'b0};
        vecs[4] = '{8'h3C, 3'd2, 1'b1};
        vecs[5] = '{8'h3C, 3'd6, 1'b0};
        vecs[6] = '{8'h81, 3'd7, 1'b1};
        vecs[7] = '{8'h81, 3'd3, 1'b0};

        n_pass = 0; n_total = 0; cyc = 0; ready_from = 0;
        mtable = 8'h00; cur_ones = 4'd0; cfg_took_at = -1;
        rst = 1'b1; cfg_valid = 0; in_valid = 0; sweep_start = 0;
        cfg_table = 8'h00; in_bits = 3'd0;
        c1_cfg_valid = 0; c1_in_valid = 0; c1_sweep = 0; c1_cfg_table = 2'b00; c1_in_bits = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset out", out, 0);
        chk("reset ones", ones_count, 0);

        // Vector table: back-to-back queries within each loaded table.
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || vecs[i].tab != vecs[i-1].tab) begin
                in_valid = 1'b0;
                load(vecs[i].tab);
            end
            in_valid = 1'b1; in_bits = vecs[i].q;
            step();
            chk("vec out", out, vecs[i].exp);
            chk("vec row", out_row, vecs[i].q);
            chk("vec valid", out_valid, 1);
        end
        in_valid = 1'b0;

        // A5 sweep with a second sweep_start mid-sweep that must be ignored.
        load(8'hA5);
        pat = 8'hA5; k = cyc; sweep_start = 1'b1;
        observe(14, 1'b1, pat, nval, dcy, ones_at);
        chk("A5 rows", nval, 8);
        chk("A5 done cycle", dcy - k, 9);
        chk("A5 ones", ones_at, 4);
        chk("A5 ready after", cfg_ready, 1);

        // Reset for two cycles in the middle of a sweep.
        sweep_start = 1'b1; step(); sweep_start = 1'b0;
        step(); step();
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("rst mid valid", out_valid, 0);
        chk("rst mid done", sweep_done, 0);
        chk("rst mid ones", ones_count, 0);
        chk("rst mid out", out, 0);
        chk("rst mid row", out_row, 0);
        in_valid = 1'b1; in_bits = 3'd7; step(); in_valid = 1'b0;
        chk("reset table q7", out, 0);

        // Sweep of the all-zero table while cfg FF is held until accepted.
        k = cyc; pat = 8'h00; sweep_start = 1'b1;
        step(); sweep_start = 1'b0;
        cfg_valid = 1'b1; cfg_table = 8'hFF; guard = 0;
        dcy = -1; ones_at = -1;
        while (!cfg_took && guard < 40) begin
            step(); guard++;
            if (sweep_done) ones_at = int'(ones_count);
        end
        cfg_valid = 1'b0;
        chk("cfg held accept cycle", cfg_took_at - k, 10);
        chk("00 ones", ones_at, 0);
        in_valid = 1'b1; in_bits = 3'd3; step(); in_valid = 1'b0;
        chk("FF query", out, 1);

        // Full-width count.
        k = cyc; pat = 8'hFF; sweep_start = 1'b1;
        observe(11, 1'b0, pat, nval, dcy, ones_at);
        chk("FF ones", ones_at, 8);

        // Same-cycle cfg and query: query sees the old table.
        load(8'hA5);
        cfg_valid = 1'b1; cfg_table = 8'h00; in_valid = 1'b1; in_bits = 3'd2;
        step();
        cfg_valid = 1'b0; in_valid = 1'b0;
        chk("cfg+query old table", out, 1);

        // Same-cycle query and sweep_start: sweep shifted by one cycle.
        load(8'h5A);
        k = cyc; in_valid = 1'b1; in_bits = 3'd1; sweep_start = 1'b1;
        step();
        in_valid = 1'b0; sweep_start = 1'b0;
        chk("q+sweep first row", out_row, 1);
        step();
        chk("q+sweep row0", out_row, 0);
        chk("q+sweep row0 out", out, 0);
        dcy = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sweep_done) dcy = cyc;
        end
        chk("q+sweep done cycle", dcy - k, 10);

        // N_IN=1 instance: table 2'b10 loaded together with sweep_start.
        c1_cfg_valid = 1'b1; c1_cfg_table = 2'b10; c1_sweep = 1'b1;
        step();
        c1_cfg_valid = 1'b0; c1_sweep = 1'b0;
        chk("n1 row0 valid", c1_out_valid, 1);
        chk("n1 row0 out", c1_out, 0);
        chk("n1 row0 row", c1_row, 0);
        step();
        chk("n1 row1 out", c1_out, 1);
        chk("n1 row1 row", c1_row, 1);
        step();
        chk("n1 done", c1_done, 1);
        chk("n1 ones", c1_ones, 1);
        chk("n1 done ready", c1_cfg_ready, 0);
        step();
        chk("n1 ready", c1_in_ready, 1);

        // Randomized traffic against the timeline model.
        for (int i = 0; i < 500; i++) begin
            rst         = ($urandom_range(0, 149) == 0);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_table   = 8'($urandom);
            in_valid    = 1'($urandom_range(0, 1));
            in_bits     = 3'($urandom);
            sweep_start = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; sweep_start = 1'b0;
        for (int i = 0; i < 12; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
